super_alu_packer: RTL

SUPER_ALU_PACKER -- requirements
Module: super_alu_packer

---
 rtl/super_alu_packer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/super_alu_packer.sv
// Collects 6-byte frames into a 41-bit super-ALU word; output registered 1 cycle after the last byte.
// Backpressure: in_ready drops only in the last-byte state while an unread word is held.
module super_alu_packer #(
   parameter int DROP_ILLEGAL = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   output logic [40:0] out_word,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err,
   output logic [7:0]  frame_cnt
);

   typedef enum logic [2:0] {
      S_B0,
      S_B1,
      S_N1,
      S_N2,
      S_N3,
      S_N4
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  op1_q, op1_d;
   logic [2:0]  op2_q, op2_d;
   logic [2:0]  op3_q, op3_d;
   logic        ill_q, ill_d;
   logic [7:0]  n1_q, n1_d;
   logic [7:0]  n2_q, n2_d;
   logic [7:0]  n3_q, n3_d;
   logic [40:0] out_word_q, out_word_d;
   logic        out_valid_q, out_valid_d;
   logic        err_q, err_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;

   logic        rdy_int;
   logic        accept;
   logic        xfer;
   logic        load;

   // The last byte may only be taken when the output slot is free or draining this edge.
   assign rdy_int = (state_q != S_N4) || !out_valid_q || out_ready;
   assign accept  = in_valid && rdy_int && rst_n;
   assign xfer    = out_valid_q && out_ready;

   always_comb begin
      state_d     = state_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      op3_d       = op3_q;
      ill_d       = ill_q;
      n1_d        = n1_q;
      n2_d        = n2_q;
      n3_d        = n3_q;
      out_word_d  = out_word_q;
      out_valid_d = out_valid_q;
      err_d       = 1'b0;
      frame_cnt_d = frame_cnt_q;
      load        = 1'b0;

      if (xfer) begin
         out_valid_d = 1'b0;
         frame_cnt_d = frame_cnt_q + 8'd1;
      end

      if (accept && !flush) begin
         case (state_q)
            S_B0: begin
               op1_d   = in_data[7:5];
               op2_d   = in_data[4:2];
               ill_d   = (in_data[7:5] == 3'b111) || (in_data[4:2] == 3'b111);
               state_d = S_B1;
            end
            S_B1: begin
               op3_d   = in_data[7:5];
               ill_d   = ill_q || (in_data[7:5] == 3'b111);
               state_d = S_N1;
            end
            S_N1: begin
               n1_d    = in_data;
               state_d = S_N2;
            end
            S_N2: begin
               n2_d    = in_data;
               state_d = S_N3;
            end
            S_N3: begin
               n3_d    = in_data;
               state_d = S_N4;
            end
            S_N4: begin
               state_d = S_B0;
               err_d   = ill_q;
               load    = !ill_q || (DROP_ILLEGAL == 0);
            end
            default: state_d = S_B0;
         endcase
      end

      // A completing word overrides the clear from a same-edge transfer, so no bubble.
      if (load) begin
         out_word_d  = {op1_q, op2_q, op3_q, n1_q, n2_q, n3_q, in_data};
         out_valid_d = 1'b1;
      end

      if (flush) begin
         state_d = S_B0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_B0;
         op1_q       <= 3'd0;
         op2_q       <= 3'd0;
         op3_q       <= 3'd0;
         ill_q       <= 1'b0;
         n1_q        <= 8'd0;
         n2_q        <= 8'd0;
         n3_q        <= 8'd0;
         out_word_q  <= 41'd0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         op3_q       <= op3_d;
         ill_q       <= ill_d;
         n1_q        <= n1_d;
         n2_q        <= n2_d;
         n3_q        <= n3_d;
         out_word_q  <= out_word_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign in_ready  = rst_n && rdy_int;
   assign out_word  = out_word_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;
   assign frame_cnt = frame_cnt_q;

endmodule
